uart_tx_arb: RTL and testbench

- Round-robin arbiter that shares one uart_tx instance between N_REQ byte producers (debug, LED status, counter dump, and so on).
- Each requester gets a valid/ready byte handshake. The arbiter sequences the START/BUSY/DATA interface of uart_tx: one START pulse per byte, then it waits for the full BUSY high/low cycle.
- The block sits between the producers in top and i_uart_tx, replacing the direct tx_start/tx_data drive.

---
 rtl/uart_tx_arb_pkg.sv | 22 ++
 rtl/uart_tx_arb_rr_pick.sv | 29 ++
 rtl/uart_tx_arb.sv | 151 +++++++++++++++
 tb/tb_uart_tx_arb.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_arb_pkg.sv
// Shared types and constants for the uart_tx arbiter and its uart_tx neighbour.
// Optional build macro used by uart_tx_arb: UART_TX_ARB_LINE_LOCK_EN.
package uart_tx_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_START   = 2'd1,
    ST_WAIT_HI = 2'd2,
    ST_WAIT_LO = 2'd3
  } arb_state_e;

  localparam logic [7:0] ASCII_LF     = 8'h0A;
  localparam int         CLK_HZ       = 12_000_000;
  localparam int         BAUD         = 115_200;
  localparam int         CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int         ID_W         = 3;

  function automatic logic [7:0] onehot8(input logic [ID_W-1:0] idx);
    onehot8 = 8'b1 << idx;
  endfunction

endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// Combinational round-robin picker: first set request after the last grant,
// wrapping modulo N. Written generically for reuse by other shared-resource arbiters.
module uart_tx_arb_rr_pick
  import uart_tx_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]    req_i,
  input  logic [ID_W-1:0] last_i,
  output logic [ID_W-1:0] idx_o,
  output logic            found_o
);

  // Padding to 8 bits keeps the 3-bit search index legal for any N in 2..8.
  logic [7:0] req_pad;
  assign req_pad = 8'(req_i);

  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (!found_o && req_pad[ID_W'((int'(last_i) + k) % N)]) begin
        found_o = 1'b1;
        idx_o   = ID_W'((int'(last_i) + k) % N);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin sharing of one uart_tx between N_REQ byte producers.
// Define UART_TX_ARB_LINE_LOCK_EN to keep a winner locked until it sends a line feed.
module uart_tx_arb
  import uart_tx_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int BUSY_TO = 15
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [N_REQ-1:0]     req_valid_i,
  input  logic [8*N_REQ-1:0]   req_data_i,
  output logic [N_REQ-1:0]     req_ready_o,
  output logic                 tx_start_o,
  output logic [7:0]           tx_data_o,
  input  logic                 tx_busy_i,
  output logic [ID_W-1:0]      grant_id_o,
  output logic                 err_to_o
`ifdef UART_TX_ARB_LINE_LOCK_EN
  ,
  output logic                 locked_o
`endif
);

  localparam int CNT_W = $clog2(BUSY_TO + 1);

  arb_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             tx_start_q;
  logic [7:0]       tx_data_q;
  logic [ID_W-1:0]  grant_id_q;
  logic             err_to_q;

  logic [7:0]       valid_pad;
  logic [7:0]       req_byte [8];
  logic [ID_W-1:0]  rr_idx;
  logic             rr_found;
  logic [ID_W-1:0]  win_idx;
  logic             win_found;
  logic [7:0]       win_byte;
  logic [7:0]       win_onehot;
  logic             grant_ok;
  logic             xfer;

  // Unused lanes read as idle so the 3-bit winner index can address them safely.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_lane
      if (gi < N_REQ) begin : g_used
        assign valid_pad[gi] = req_valid_i[gi];
        assign req_byte[gi]  = req_data_i[8*gi +: 8];
      end else begin : g_unused
        assign valid_pad[gi] = 1'b0;
        assign req_byte[gi]  = 8'h00;
      end
    end
  endgenerate

  uart_tx_arb_rr_pick #(
    .N (N_REQ)
  ) u_rr_pick (
    .req_i   (req_valid_i),
    .last_i  (grant_id_q),
    .idx_o   (rr_idx),
    .found_o (rr_found)
  );

`ifdef UART_TX_ARB_LINE_LOCK_EN
  logic locked_q;

  // While locked, only the owner of the current line may be granted.
  always_comb begin
    if (locked_q) begin
      win_idx   = grant_id_q;
      win_found = valid_pad[grant_id_q];
    end else begin
      win_idx   = rr_idx;
      win_found = rr_found;
    end
  end

  assign locked_o = locked_q;
`else
  assign win_idx   = rr_idx;
  assign win_found = rr_found;
`endif

  assign win_byte    = req_byte[win_idx];
  assign win_onehot  = onehot8(win_idx);
  assign grant_ok    = (state_q == ST_IDLE) && !tx_busy_i && win_found;
  assign req_ready_o = grant_ok ? win_onehot[N_REQ-1:0] : '0;
  assign xfer        = |(req_valid_i & req_ready_o);
  assign cnt_d       = cnt_q + 1'b1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      grant_id_q <= ID_W'(N_REQ - 1);
      err_to_q   <= 1'b0;
`ifdef UART_TX_ARB_LINE_LOCK_EN
      locked_q   <= 1'b0;
`endif
    end else begin
      tx_start_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (xfer) begin
            state_q    <= ST_START;
            tx_start_q <= 1'b1;
            tx_data_q  <= win_byte;
            grant_id_q <= win_idx;
`ifdef UART_TX_ARB_LINE_LOCK_EN
            locked_q   <= (win_byte != ASCII_LF);
`endif
          end
        end
        ST_START: begin
          state_q <= ST_WAIT_HI;
          cnt_q   <= '0;
        end
        ST_WAIT_HI: begin
          if (tx_busy_i) begin
            state_q <= ST_WAIT_LO;
          end else begin
            cnt_q <= cnt_d;
            // uart_tx never acknowledged the byte; give up on it.
            if (cnt_d == CNT_W'(BUSY_TO)) begin
              err_to_q <= 1'b1;
              state_q  <= ST_IDLE;
            end
          end
        end
        ST_WAIT_LO: begin
          if (!tx_busy_i) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign tx_start_o = tx_start_q;
  assign tx_data_o  = tx_data_q;
  assign grant_id_o = grant_id_q;
  assign err_to_o   = err_to_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed self-checking bench for uart_tx_arb with a small uart_tx BUSY model.
// Build with UART_TX_ARB_LINE_LOCK_EN to also exercise the line-lock scenario.
module tb_uart_tx_arb;

  localparam int N_REQ   = 4;
  localparam int BUSY_TO = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_ready;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic [2:0]  grant_id;
  logic        err_to;
`ifdef UART_TX_ARB_LINE_LOCK_EN
  logic        locked;
`endif

  logic        man_busy = 1'b0;
  logic        auto_busy = 1'b0;
  logic [3:0]  bm_cnt = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_arb #(
    .N_REQ   (N_REQ),
    .BUSY_TO (BUSY_TO)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_data_i  (req_data),
    .req_ready_o (req_ready),
    .tx_start_o  (tx_start),
    .tx_data_o   (tx_data),
    .tx_busy_i   (tx_busy),
    .grant_id_o  (grant_id),
    .err_to_o    (err_to)
`ifdef UART_TX_ARB_LINE_LOCK_EN
    ,
    .locked_o    (locked)
`endif
  );

  // uart_tx model: BUSY high for cycles 3..6 after the START cycle.
  assign tx_busy = auto_busy ? (bm_cnt >= 4'd3 && bm_cnt <= 4'd6) : man_busy;

  always @(posedge clk) begin
    if (!auto_busy)          bm_cnt <= '0;
    else if (bm_cnt == 4'd7) bm_cnt <= '0;
    else if (tx_start)       bm_cnt <= 4'd1;
    else if (bm_cnt != 0)    bm_cnt <= bm_cnt + 4'd1;
  end

  always @(negedge clk) begin
    if (tx_start) $display("tx byte %02h from requester %0d", tx_data, grant_id);
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = '0; req_data = '0; auto_busy = 1'b0; man_busy = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = '0; auto_busy = 1'b0; man_busy = 1'b0;
    @(negedge clk); #1;
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start got %0h want 0", tx_start); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got %02h want 00", tx_data); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b want 0000", req_ready); end
    checks++; if (grant_id !== 3'd3) begin errors++; $display("FAIL reset_grant_id got %0d want 3", grant_id); end
    checks++; if (err_to !== 1'b0) begin errors++; $display("FAIL reset_err_to got %0h want 0", err_to); end
`ifdef UART_TX_ARB_LINE_LOCK_EN
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got %0h want 0", locked); end
`endif
    rst = 1'b0;
  endtask

  task automatic test_single();
    int  first_k;
    logic saw_busy;
    do_reset();
    auto_busy = 1'b1;
    @(negedge clk);
    req_data[15:8] = 8'h41; req_valid = 4'b0010;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL single_ready got %b want 0010", req_ready); end
    @(negedge clk);
    req_data[15:8] = 8'h42;
    #1;
    checks++; if (tx_start !== 1'b1) begin errors++; $display("FAIL single_start got %0h want 1", tx_start); end
    checks++; if (tx_data !== 8'h41) begin errors++; $display("FAIL single_data got %02h want 41", tx_data); end
    checks++; if (grant_id !== 3'd1) begin errors++; $display("FAIL single_grant_id got %0d want 1", grant_id); end
    // BUSY high cycles 3..6, WAIT_LO exits at end of cycle 7, grant in cycle 8.
    first_k = 0; saw_busy = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk); #1;
      if (tx_busy) saw_busy = 1'b1;
      if (req_ready !== 4'b0000) begin first_k = k; break; end
    end
    checks++; if (first_k != 8) begin errors++; $display("FAIL single_next_grant_cycle got %0d want 8", first_k); end
    checks++; if (saw_busy !== 1'b1) begin errors++; $display("FAIL single_busy_seen got %0h want 1", saw_busy); end
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL single_second_ready got %b want 0010", req_ready); end
    @(negedge clk);
    req_valid = '0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_rotation();
    logic [7:0] got [5];
    logic [7:0] exp_b [5];
    int starts, accepts;
    logic multi;
    exp_b[0] = 8'h30; exp_b[1] = 8'h31; exp_b[2] = 8'h32; exp_b[3] = 8'h33; exp_b[4] = 8'h30;
    for (int i = 0; i < 5; i++) got[i] = 8'h00;
    starts = 0; accepts = 0; multi = 1'b0;
    do_reset();
    auto_busy = 1'b1;
    for (int c = 0; c < 300 && starts < 5; c++) begin
      @(negedge clk);
      if (c == 0) begin
        req_data = 32'h3332_3130; req_valid = 4'b1111;
      end
      #1;
      if ($countones(req_ready) > 1) multi = 1'b1;
      if (req_ready !== 4'b0000) accepts++;
      if (tx_start === 1'b1) begin got[starts] = tx_data; starts++; end
    end
    checks++; if (starts != 5) begin errors++; $display("FAIL rot_starts got %0d want 5", starts); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (got[i] !== exp_b[i]) begin errors++; $display("FAIL rot_byte%0d got %02h want %02h", i, got[i], exp_b[i]); end
    end
    checks++; if (accepts != starts) begin errors++; $display("FAIL rot_accepts got %0d want %0d", accepts, starts); end
    checks++; if (multi !== 1'b0) begin errors++; $display("FAIL rot_onehot got %0h want 0", multi); end
  endtask

  task automatic test_timeout();
    int k_err;
    do_reset();
    @(negedge clk);
    req_data[23:16] = 8'h55; req_valid = 4'b0100;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL to_ready got %b want 0100", req_ready); end
    @(negedge clk);
    req_data[31:24] = 8'h66; req_valid = 4'b1000;
    #1;
    checks++; if (tx_start !== 1'b1) begin errors++; $display("FAIL to_start got %0h want 1", tx_start); end
    // One START cycle plus BUSY_TO WAIT_HI cycles before ERR_TO shows.
    k_err = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk); #1;
      if (err_to === 1'b1) begin k_err = k; break; end
    end
    checks++; if (k_err != BUSY_TO + 1) begin errors++; $display("FAIL to_err_cycle got %0d want %0d", k_err, BUSY_TO + 1); end
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL to_next_ready got %b want 1000", req_ready); end
    @(negedge clk);
    req_valid = '0;
    #1;
    checks++; if (tx_data !== 8'h66) begin errors++; $display("FAIL to_next_data got %02h want 66", tx_data); end
    repeat (25) @(negedge clk);
    #1;
    checks++; if (err_to !== 1'b1) begin errors++; $display("FAIL to_sticky got %0h want 1", err_to); end
  endtask

  task automatic test_rst_mid();
    logic blk;
    do_reset();
    @(negedge clk);
    req_data[7:0] = 8'h77; req_valid = 4'b0001;
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    man_busy = 1'b1;
    @(negedge clk);
    rst = 1'b1; req_data[15:8] = 8'h12; req_valid = 4'b0010;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL rst_tx_start got %0h want 0", tx_start); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL rst_tx_data got %02h want 00", tx_data); end
    checks++; if (grant_id !== 3'd3) begin errors++; $display("FAIL rst_grant_id got %0d want 3", grant_id); end
    checks++; if (err_to !== 1'b0) begin errors++; $display("FAIL rst_err_to got %0h want 0", err_to); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rst_ready_busy got %b want 0000", req_ready); end
    blk = 1'b0;
    repeat (3) begin
      @(negedge clk); #1;
      if (req_ready !== 4'b0000) blk = 1'b1;
    end
    checks++; if (blk !== 1'b0) begin errors++; $display("FAIL rst_grant_while_busy got %0h want 0", blk); end
    @(negedge clk);
    man_busy = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL rst_ready_after_busy got %b want 0010", req_ready); end
    @(negedge clk);
    req_valid = '0;
  endtask

  task automatic test_drop_valid();
    logic saw_r2;
    int   extra;
    do_reset();
    auto_busy = 1'b1;
    @(negedge clk);
    req_data = 32'h0022_1100; req_valid = 4'b0010;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL drop_r1_ready got %b want 0010", req_ready); end
    @(negedge clk);
    req_valid = 4'b0100;
    #1;
    saw_r2 = req_ready[2];
    extra = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (c == 2) req_valid = '0;
      #1;
      if (req_ready[2] === 1'b1) saw_r2 = 1'b1;
      if (tx_start === 1'b1) extra++;
    end
    checks++; if (saw_r2 !== 1'b0) begin errors++; $display("FAIL drop_r2_ready got %0h want 0", saw_r2); end
    checks++; if (extra != 0) begin errors++; $display("FAIL drop_extra_starts got %0d want 0", extra); end
  endtask

`ifdef UART_TX_ARB_LINE_LOCK_EN
  task automatic test_line_lock();
    logic [7:0] seq [3];
    int   order [4];
    logic lk [4];
    int   grants, r0, gid;
    logic lk_after_a, lk_after_lf;
    seq[0] = 8'h41; seq[1] = 8'h42; seq[2] = 8'h0A;
    for (int i = 0; i < 4; i++) begin order[i] = -1; lk[i] = 1'bx; end
    grants = 0; r0 = 0; lk_after_a = 1'b0; lk_after_lf = 1'b1;
    do_reset();
    auto_busy = 1'b1;
    for (int c = 0; c < 300 && grants < 4; c++) begin
      @(negedge clk);
      req_valid[0]   = (r0 < 3);
      req_data[7:0]  = (r0 < 3) ? seq[r0] : 8'h00;
      req_data[31:24] = 8'h5A;
      req_valid[3]   = 1'b1;
      #1;
      if (tx_start === 1'b1 && tx_data == 8'h41) lk_after_a = locked;
      if (tx_start === 1'b1 && tx_data == 8'h0A) lk_after_lf = locked;
      if (req_ready !== 4'b0000) begin
        gid = -1;
        for (int i = 0; i < 4; i++) if (req_ready[i]) gid = i;
        order[grants] = gid;
        lk[grants] = locked;
        grants++;
        if (req_ready[0]) r0++;
      end
    end
    req_valid = '0;
    checks++; if (grants != 4) begin errors++; $display("FAIL lock_grants got %0d want 4", grants); end
    checks++; if (order[0] != 0) begin errors++; $display("FAIL lock_order0 got %0d want 0", order[0]); end
    checks++; if (order[1] != 0) begin errors++; $display("FAIL lock_order1 got %0d want 0", order[1]); end
    checks++; if (order[2] != 0) begin errors++; $display("FAIL lock_order2 got %0d want 0", order[2]); end
    checks++; if (order[3] != 3) begin errors++; $display("FAIL lock_order3 got %0d want 3", order[3]); end
    checks++; if (lk_after_a !== 1'b1) begin errors++; $display("FAIL lock_after_A got %0h want 1", lk_after_a); end
    checks++; if (lk[1] !== 1'b1) begin errors++; $display("FAIL lock_at_B_grant got %0h want 1", lk[1]); end
    checks++; if (lk[2] !== 1'b1) begin errors++; $display("FAIL lock_at_LF_grant got %0h want 1", lk[2]); end
    checks++; if (lk_after_lf !== 1'b0) begin errors++; $display("FAIL lock_after_LF got %0h want 0", lk_after_lf); end
    repeat (10) @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_timeout();
    test_rst_mid();
    test_drop_valid();
`ifdef UART_TX_ARB_LINE_LOCK_EN
    test_line_lock();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
